// File: rtl/brief_window_gen_if.sv
// 31x31 BRIEF window bus between the window generator and the descriptor stage.
// Optional BRIEF_WIN_COORD_EN adds the window-centre coordinates win_x/win_y.
interface interface_windows #(
    parameter int Pra_Width = 8
);
    logic image_vs;
    logic image_hs;
    logic image_en;
    logic [30:0][Pra_Width-1:0] window_00, window_01, window_02, window_03, window_04,
                                window_05, window_06, window_07, window_08, window_09,
                                window_10, window_11, window_12, window_13, window_14,
                                window_15, window_16, window_17, window_18, window_19,
                                window_20, window_21, window_22, window_23, window_24,
                                window_25, window_26, window_27, window_28, window_29,
                                window_30;
`ifdef BRIEF_WIN_COORD_EN
    logic [15:0] win_x;
    logic [15:0] win_y;
`endif

    modport o_window (
        output image_vs, image_hs, image_en,
        output window_00, window_01, window_02, window_03, window_04,
               window_05, window_06, window_07, window_08, window_09,
               window_10, window_11, window_12, window_13, window_14,
               window_15, window_16, window_17, window_18, window_19,
               window_20, window_21, window_22, window_23, window_24,
               window_25, window_26, window_27, window_28, window_29,
               window_30
`ifdef BRIEF_WIN_COORD_EN
        , output win_x, win_y
`endif
    );

    modport i_window (
        input image_vs, image_hs, image_en,
        input window_00, window_01, window_02, window_03, window_04,
              window_05, window_06, window_07, window_08, window_09,
              window_10, window_11, window_12, window_13, window_14,
              window_15, window_16, window_17, window_18, window_19,
              window_20, window_21, window_22, window_23, window_24,
              window_25, window_26, window_27, window_28, window_29,
              window_30
`ifdef BRIEF_WIN_COORD_EN
        , input win_x, win_y
`endif
    );
endinterface

// File: rtl/brief_window_gen.sv
// Builds fully-populated 31x31 windows from a raster stream using 30 line buffers.
// Define BRIEF_WIN_COORD_EN to also publish the window centre (win_x, win_y).
module brief_window_gen #(
    parameter int Pra_Width = 8,
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int WIN       = 31
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vs,
    input  logic                 in_hs,
    input  logic                 in_en,
    input  logic [Pra_Width-1:0] in_data,
    interface_windows.o_window   win
);
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int NLB = WIN - 1;

    localparam logic [1:0] S_WAIT_VS = 2'd0;
    localparam logic [1:0] S_FILL    = 2'd1;
    localparam logic [1:0] S_STREAM  = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_EDGE      = CW'(WIN - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FILL_LAST = RW'(WIN - 2);

    if (WIN != 31) begin : g_win_check
        $error("brief_window_gen: WIN must be 31");
    end

    logic [1:0]                           r_state;
    logic [CW-1:0]                        r_col;
    logic [RW-1:0]                        r_row;
    logic                                 r_vs;
    logic                                 r_hs;
    logic                                 r_en;
    logic [WIN-1:0][Pra_Width-1:0]        r_win [0:WIN-1];
    logic [Pra_Width-1:0]                 r_lb  [0:NLB-1][0:IMG_W-1];
    logic [Pra_Width-1:0]                 w_lb_rd [0:NLB-1];
    logic                                 w_accept;
`ifdef BRIEF_WIN_COORD_EN
    logic [15:0]                          r_win_x;
    logic [15:0]                          r_win_y;
`endif

    assign w_accept = in_en && !in_vs && (r_state == S_FILL || r_state == S_STREAM);

    always_comb begin
        for (int unsigned k = 0; k < NLB; k++) begin
            w_lb_rd[k] = r_lb[k][r_col];
        end
    end

    // Read-before-write chain: buffer k takes buffer k+1's old pixel, the last takes in_data.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int unsigned k = 0; k < NLB - 1; k++) begin
                r_lb[k][r_col] <= w_lb_rd[k+1];
            end
            r_lb[NLB-1][r_col] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_WAIT_VS;
            r_col   <= '0;
            r_row   <= '0;
            r_vs    <= 1'b0;
            r_hs    <= 1'b0;
            r_en    <= 1'b0;
            for (int unsigned r = 0; r < WIN; r++) begin
                r_win[r] <= '0;
            end
`ifdef BRIEF_WIN_COORD_EN
            r_win_x <= '0;
            r_win_y <= '0;
`endif
        end else begin
            r_vs <= in_vs;
            r_hs <= in_hs;
            r_en <= 1'b0;
            if (in_vs) begin
                r_state <= S_FILL;
                r_col   <= '0;
                r_row   <= '0;
            end else if (w_accept) begin
                for (int unsigned r = 0; r < WIN - 1; r++) begin
                    r_win[r] <= {w_lb_rd[r], r_win[r][WIN-1:1]};
                end
                r_win[WIN-1] <= {in_data, r_win[WIN-1][WIN-1:1]};

                if (r_state == S_STREAM && r_col >= COL_EDGE) begin
                    r_en <= 1'b1;
`ifdef BRIEF_WIN_COORD_EN
                    r_win_x <= 16'(r_col) - 16'd15;
                    r_win_y <= 16'(r_row) - 16'd15;
`endif
                end

                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    if (r_state == S_STREAM && r_row == ROW_LAST) begin
                        r_row   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_row <= r_row + 1'b1;
                        if (r_row == ROW_FILL_LAST) begin
                            r_state <= S_STREAM;
                        end
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign win.image_vs  = r_vs;
    assign win.image_hs  = r_hs;
    assign win.image_en  = r_en;
    assign win.window_00 = r_win[0];
    assign win.window_01 = r_win[1];
    assign win.window_02 = r_win[2];
    assign win.window_03 = r_win[3];
    assign win.window_04 = r_win[4];
    assign win.window_05 = r_win[5];
    assign win.window_06 = r_win[6];
    assign win.window_07 = r_win[7];
    assign win.window_08 = r_win[8];
    assign win.window_09 = r_win[9];
    assign win.window_10 = r_win[10];
    assign win.window_11 = r_win[11];
    assign win.window_12 = r_win[12];
    assign win.window_13 = r_win[13];
    assign win.window_14 = r_win[14];
    assign win.window_15 = r_win[15];
    assign win.window_16 = r_win[16];
    assign win.window_17 = r_win[17];
    assign win.window_18 = r_win[18];
    assign win.window_19 = r_win[19];
    assign win.window_20 = r_win[20];
    assign win.window_21 = r_win[21];
    assign win.window_22 = r_win[22];
    assign win.window_23 = r_win[23];
    assign win.window_24 = r_win[24];
    assign win.window_25 = r_win[25];
    assign win.window_26 = r_win[26];
    assign win.window_27 = r_win[27];
    assign win.window_28 = r_win[28];
    assign win.window_29 = r_win[29];
    assign win.window_30 = r_win[30];
`ifdef BRIEF_WIN_COORD_EN
    assign win.win_x = r_win_x;
    assign win.win_y = r_win_y;
`endif
endmodule

// File: tb/tb_brief_window_gen.sv
// Scoreboard bench for brief_window_gen on a 40x35 frame with pixel(y,x) = (y*40+x) & 0xFF.
module tb_brief_window_gen;
    localparam int PW = 8;
    localparam int IW = 40;
    localparam int IH = 35;

    typedef struct { int y; int x; } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vs = 1'b0;
    logic          in_hs = 1'b0;
    logic          in_en = 1'b0;
    logic [PW-1:0] in_data = '0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_en     = 0;
    bit   mon_on   = 1'b0;
    logic exp_vs = 1'b0, exp_hs = 1'b0, prev_idle = 1'b1;
    exp_t sb[$];

    logic [30:0][PW-1:0] w_rows [0:30];

    always #5 clk = ~clk;

    interface_windows #(.Pra_Width(PW)) wif ();

    brief_window_gen #(.Pra_Width(PW), .IMG_W(IW), .IMG_H(IH), .WIN(31)) dut (
        .clk(clk), .rst_n(rst_n), .in_vs(in_vs), .in_hs(in_hs),
        .in_en(in_en), .in_data(in_data), .win(wif)
    );

    assign w_rows[0]  = wif.window_00;  assign w_rows[1]  = wif.window_01;
    assign w_rows[2]  = wif.window_02;  assign w_rows[3]  = wif.window_03;
    assign w_rows[4]  = wif.window_04;  assign w_rows[5]  = wif.window_05;
    assign w_rows[6]  = wif.window_06;  assign w_rows[7]  = wif.window_07;
    assign w_rows[8]  = wif.window_08;  assign w_rows[9]  = wif.window_09;
    assign w_rows[10] = wif.window_10;  assign w_rows[11] = wif.window_11;
    assign w_rows[12] = wif.window_12;  assign w_rows[13] = wif.window_13;
    assign w_rows[14] = wif.window_14;  assign w_rows[15] = wif.window_15;
    assign w_rows[16] = wif.window_16;  assign w_rows[17] = wif.window_17;
    assign w_rows[18] = wif.window_18;  assign w_rows[19] = wif.window_19;
    assign w_rows[20] = wif.window_20;  assign w_rows[21] = wif.window_21;
    assign w_rows[22] = wif.window_22;  assign w_rows[23] = wif.window_23;
    assign w_rows[24] = wif.window_24;  assign w_rows[25] = wif.window_25;
    assign w_rows[26] = wif.window_26;  assign w_rows[27] = wif.window_27;
    assign w_rows[28] = wif.window_28;  assign w_rows[29] = wif.window_29;
    assign w_rows[30] = wif.window_30;

    function automatic logic [PW-1:0] pix(int y, int x);
        return PW'((y * IW + x) % 256);
    endfunction

    function automatic void check(string nm, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endfunction

    function automatic int win_or();
        int acc = 0;
        for (int r = 0; r < 31; r++)
            for (int c = 0; c < 31; c++)
                acc = acc | int'(w_rows[r][c]);
        return acc;
    endfunction

    always @(posedge clk) begin
        exp_vs    <= in_vs;
        exp_hs    <= in_hs;
        prev_idle <= !in_en;
    end

    // Monitor: pops one expected window per image_en and compares the full 31x31 array.
    always @(negedge clk) begin
        if (mon_on) begin
            check("image_vs_delay", int'(wif.image_vs), int'(exp_vs));
            check("image_hs_delay", int'(wif.image_hs), int'(exp_hs));
            if (prev_idle) check("en_after_idle", int'(wif.image_en), 0);
            if (wif.image_en) begin
                n_en++;
                if (sb.size() == 0) begin
                    check("unexpected_image_en", 1, 0);
                end else begin
                    exp_t e;
                    int   bad_r, bad_c;
                    e = sb.pop_front();
                    bad_r = -1;
                    bad_c = -1;
                    for (int r = 0; r < 31; r++)
                        for (int c = 0; c < 31; c++)
                            if (bad_r < 0 && w_rows[r][c] != pix(e.y - 30 + r, e.x - 30 + c)) begin
                                bad_r = r;
                                bad_c = c;
                            end
                    n_checks++;
                    if (bad_r >= 0) begin
                        n_fail++;
                        $display("FAIL window(%0d,%0d) [%0d][%0d]: got %0d, expected %0d",
                                 e.y, e.x, bad_r, bad_c, w_rows[bad_r][bad_c],
                                 pix(e.y - 30 + bad_r, e.x - 30 + bad_c));
                    end
                    if (e.y == 30 && e.x == 30) begin
                        check("first_w00_0", int'(w_rows[0][0]), 0);
                        check("first_w30_30", int'(w_rows[30][30]), 206);
                        check("first_w15_15", int'(w_rows[15][15]), 103);
                    end
                    if (e.y == 34 && e.x == 39) check("last_w30_30", int'(w_rows[30][30]), 119);
`ifdef BRIEF_WIN_COORD_EN
                    check("win_x", int'(wif.win_x), e.x - 15);
                    check("win_y", int'(wif.win_y), e.y - 15);
                    if (e.y == 30 && e.x == 30) begin
                        check("first_win_x", int'(wif.win_x), 15);
                        check("first_win_y", int'(wif.win_y), 15);
                    end
                    if (e.y == 34 && e.x == 39) begin
                        check("last_win_x", int'(wif.win_x), 24);
                        check("last_win_y", int'(wif.win_y), 19);
                    end
`endif
                end
            end
        end
    end

    task automatic cyc(input bit vs, input bit hs, input bit en, input logic [PW-1:0] d);
        in_vs   = vs;
        in_hs   = hs;
        in_en   = en;
        in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic vs_pulse();
        cyc(1'b1, 1'b0, 1'b0, '0);
        idle(1);
    endtask

    task automatic pixel(input int y, input int x, input bit push, input int gap_pct);
        if (gap_pct > 0)
            while ($urandom_range(0, 99) < gap_pct) idle(1);
        if (push && y >= 30 && x >= 30) sb.push_back('{y: y, x: x});
        cyc(1'b0, x == 0, 1'b1, pix(y, x));
    endtask

    task automatic frame(input bit push, input int gap_pct);
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++)
                pixel(y, x, push, gap_pct);
    endtask

    initial begin
        int base;
        idle(3);
        check("reset_image_vs", int'(wif.image_vs), 0);
        check("reset_image_en", int'(wif.image_en), 0);
        check("reset_windows", win_or(), 0);
        rst_n = 1'b1;
        idle(2);
        mon_on = 1'b1;

        // Continuous full frame
        vs_pulse();
        base = n_en;
        frame(1'b1, 0);
        idle(4);
        check("frame_count_continuous", n_en - base, 50);

        // Same frame with ~30% idle cycles
        vs_pulse();
        base = n_en;
        frame(1'b1, 30);
        idle(4);
        check("frame_count_gaps", n_en - base, 50);

        // One-cycle reset at pixel (20,5), then pixels with no frame start
        vs_pulse();
        base = n_en;
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++) begin
                if (y == 20 && x == 5) begin
                    rst_n = 1'b0;
                    cyc(1'b0, 1'b0, 1'b1, pix(y, x));
                    rst_n = 1'b1;
                end else begin
                    pixel(y, x, 1'b0, 0);
                end
            end
        idle(4);
        check("count_after_reset", n_en - base, 0);
        check("windows_after_reset", win_or(), 0);
        vs_pulse();
        base = n_en;
        frame(1'b1, 0);
        idle(4);
        check("frame_count_post_reset", n_en - base, 50);

        // Frame restart at (32,10) with in_en high, then a full frame, then DONE
        vs_pulse();
        base = n_en;
        for (int y = 0; y < IH && !(y == 32); y++)
            for (int x = 0; x < IW; x++) pixel(y, x, 1'b1, 0);
        for (int x = 0; x < 10; x++) pixel(32, x, 1'b1, 0);
        cyc(1'b1, 1'b0, 1'b1, pix(32, 10));
        frame(1'b1, 0);
        idle(4);
        check("count_restart", n_en - base, 70);
        base = n_en;
        frame(1'b0, 0);
        idle(4);
        check("count_in_done", n_en - base, 0);

        // Sync delay from WAIT_VS with arbitrary vs/hs patterns
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++)
            cyc(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), PW'($urandom_range(0, 255)));
        idle(4);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/brief_window_gen.md
Name: brief_window_gen

Overview:
- Producer side of the 31x31 BRIEF sliding-window bus in the ORB pipeline.
- Takes a raster pixel stream (vs/hs/en + luminance) and builds the window from 30 line buffers plus a 31x31 shift-register array.
- Drives interface_windows through the o_window modport toward the BRIEF descriptor stage.
- Emits only fully-populated windows; no border padding.

Parameters:
Pra_Width, 8, pixel luminance width
IMG_W, 640, active pixels per line (>= 31)
IMG_H, 480, active lines per frame (>= 31)
WIN, 31, window edge; fixed at 31, checked by elaboration assertion

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low
in_vs  input  1  frame start; high for >=1 cycle before the first pixel
in_hs  input  1  line sync; forwarded only, not used for counting
in_en  input  1  pixel valid
in_data  input  Pra_Width  pixel luminance
win  interface  -  interface_windows.o_window; drives image_vs/hs/en, window_00..window_30

Behaviour:
- Reset: rst_n sampled on the clk edge only.
- Reset values: image_vs/hs/en = 0; all window_RR[CC] = 0; col/row counters = 0; state = WAIT_VS.
- Line-buffer RAM contents are not reset.
- Geometry:
  - window_RR = image row (y-30+RR); window_00 is the oldest line, window_30 is the current line.
  - Index [CC] = column (x-30+CC); [30] is the newest pixel.
- Shift rule, on each in_en=1 accepted in FILL or STREAM:
  - Every row shifts left one column.
  - window_30[30] <= in_data.
  - window_RR[30] <= line buffer RR output at column x, i.e. pixel (y-30+RR, x).
  - Line buffer chain advances: buffer k is written with buffer k+1's output; the last buffer is written with in_data.
  - Buffers are addressed by col_cnt; read and write occur in the same cycle (read-before-write).
- Counters:
  - col_cnt runs 0..IMG_W-1 and increments per accepted pixel.
  - On wrap, col_cnt returns to 0 and row_cnt increments.
  - Both are $clog2 of their dimension wide.
- State machine:
  - WAIT_VS: in_en ignored. in_vs=1 clears the counters -> FILL.
  - FILL: row_cnt < 30. Pixels shift in, image_en held 0. Moves to STREAM when row_cnt reaches 30.
  - STREAM: image_en = 1 the cycle after any accepted pixel with col_cnt >= 30. After pixel (IMG_H-1, IMG_W-1) -> DONE.
  - DONE: in_en ignored until in_vs=1 -> FILL, counters cleared.
- in_vs=1 in any state restarts the frame (counters cleared, -> FILL). An in_en pulse in the same cycle is discarded.
- Latency:
  - Window arrays and image_en are registered, 1 cycle after the accepted pixel.
  - image_vs/image_hs = in_vs/in_hs delayed 1 cycle, in every state.
- Stall: in_en=0 -> no shift, counters hold, image_en=0, window contents hold.
- Output count: exactly (IMG_W-30)*(IMG_H-30) image_en pulses per complete frame.
- Line-boundary columns (col_cnt < 30) shift in but never assert image_en.
- Reset mid-frame:
  - All outputs return to reset values on the next edge.
  - Pixels are ignored until the next in_vs.
  - Stale line-buffer data is never exposed, because FILL masks it.

Optional Feature:
BRIEF_WIN_COORD_EN
- Defined: adds outputs win_x and win_y, 16 bits each, registered with image_en.
  - win_x = col_cnt-15 and win_y = row_cnt-15, i.e. the window center in image coordinates.
  - Both reset to 0 and hold while image_en=0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Setup for all cases: IMG_W=40, IMG_H=35; pixel(y,x) = (y*40+x)&0xFF; in_en continuous after in_vs.
- Full frame -> exactly 50 image_en pulses.
  - First pulse follows pixel (30,30): window_00[0]=0, window_30[30]=206, window_15[15]=(15*40+15)&0xFF=103.
  - Last pulse: window_30[30]=pixel(34,39)=(1399)&0xFF=119.
- Random in_en gaps (~30% idle), same frame -> identical 50 windows in the same order; image_en=0 on every cycle following an idle input cycle.
- rst_n=0 for 1 cycle at pixel (20,5), then pixels without in_vs -> outputs 0, zero image_en. A following in_vs and full frame -> 50 correct windows.
- in_vs asserted mid-frame at (32,10), together with in_en=1 -> that pixel discarded, restart in FILL, the next full frame yields 50 correct windows. Pixels after the frame end (DONE) produce no image_en.
- image_vs/image_hs equal in_vs/in_hs delayed exactly 1 cycle for arbitrary patterns, including while in WAIT_VS.
- With BRIEF_WIN_COORD_EN: first window win_x=15, win_y=15; last window win_x=24, win_y=19.
